// File: rtl/ahb2_arbiter.sv
// Round-robin AHB2 bus arbiter: holds grant through fixed bursts and locked sequences, parks on DEFAULT_MST.
// Define AHB2_ARB_SPLIT_EN to add SPLIT masking with the hsplit release input.
module ahb2_arbiter #(
  parameter int NUM_MST     = 4,
  parameter int DEFAULT_MST = 0,
  localparam int MW         = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic [1:0]         hresp,
`ifdef AHB2_ARB_SPLIT_EN
  input  logic [NUM_MST-1:0] hsplit,
`endif
  output logic [NUM_MST-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic               hmastlock
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SPLIT   = 2'b11;

  logic [4:0]         beat_cnt;
  logic [4:0]         cnt_next;
  logic [MW-1:0]      rr_ptr;
  logic [MW-1:0]      rr_next;
  logic [MW-1:0]      owner;
  logic [MW-1:0]      win_idx;
  logic [MW-1:0]      park_idx;
  logic               win_found;
  logic               hold_grant;
  logic [NUM_MST-1:0] elig;
  logic [NUM_MST-1:0] grant_next;

  // beat_cnt tracks SEQ beats still owed by the current fixed-length burst
  always_comb begin
    cnt_next = beat_cnt;
    if (hresp != RESP_OKAY) begin
      cnt_next = '0;
    end else if (hready) begin
      case (htrans)
        TRANS_NONSEQ: begin
          case (hburst)
            3'd2, 3'd3: cnt_next = 5'd3;
            3'd4, 3'd5: cnt_next = 5'd7;
            3'd6, 3'd7: cnt_next = 5'd15;
            default:    cnt_next = 5'd0;
          endcase
        end
        TRANS_SEQ: begin
          if (beat_cnt != 5'd0) cnt_next = beat_cnt - 5'd1;
        end
        default: cnt_next = beat_cnt;
      endcase
    end
  end

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (hgrant[i]) owner = MW'(i);
    end
  end

`ifdef AHB2_ARB_SPLIT_EN
  logic [NUM_MST-1:0] split_mask;
  logic [NUM_MST-1:0] split_set;

  always_comb begin
    split_set = '0;
    if (hresp == RESP_SPLIT && !hready) split_set[hmaster] = 1'b1;
  end

  always_ff @(posedge hclk) begin
    if (hreset) split_mask <= '0;
    else        split_mask <= (split_mask | split_set) & ~hsplit;
  end

  always_comb begin
    elig     = hbusreq & ~split_mask;
    park_idx = MW'(DEFAULT_MST);
    // a split default master cannot park; fall back to the lowest available one
    if (split_mask[DEFAULT_MST]) begin
      for (int i = NUM_MST - 1; i >= 0; i--) begin
        if (!split_mask[i]) park_idx = MW'(i);
      end
    end
  end
`else
  always_comb begin
    elig     = hbusreq;
    park_idx = MW'(DEFAULT_MST);
  end
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int k = 1; k <= NUM_MST; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_MST;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = MW'(idx);
      end
    end
  end

  // switching at cnt_next==1 lets the next owner drive address right after the last beat
  always_comb begin
    hold_grant = (cnt_next > 5'd1) || (hlock[owner] && elig[owner]);
    grant_next = hgrant;
    rr_next    = rr_ptr;
    if (!hold_grant) begin
      if (win_found) begin
        grant_next = NUM_MST'(1) << win_idx;
        rr_next    = win_idx;
      end else begin
        grant_next = NUM_MST'(1) << park_idx;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant    <= NUM_MST'(1) << DEFAULT_MST;
      hmaster   <= MW'(DEFAULT_MST);
      hmastlock <= 1'b0;
      rr_ptr    <= MW'(DEFAULT_MST);
      beat_cnt  <= '0;
    end else begin
      beat_cnt <= cnt_next;
      if (hready) begin
        hgrant    <= grant_next;
        rr_ptr    <= rr_next;
        hmaster   <= owner;
        hmastlock <= hlock[owner];
      end
    end
  end

endmodule

// File: tb/tb_ahb2_arbiter.sv
// Randomized and directed bench for ahb2_arbiter against a distance-based round-robin reference model.
module tb_ahb2_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;
  localparam int MW  = 2;

  logic           hclk = 1'b0;
  logic           hreset;
  logic [N-1:0]   hbusreq;
  logic [N-1:0]   hlock;
  logic [1:0]     htrans;
  logic [2:0]     hburst;
  logic           hready;
  logic [1:0]     hresp;
  logic [N-1:0]   hgrant;
  logic [MW-1:0]  hmaster;
  logic           hmastlock;
`ifdef AHB2_ARB_SPLIT_EN
  logic [N-1:0]   hsplit;
`endif

  ahb2_arbiter #(.NUM_MST(N), .DEFAULT_MST(DEF)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
`ifdef AHB2_ARB_SPLIT_EN
    .hsplit    (hsplit),
`endif
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_err = 0;

  int       m_grant, m_master, m_rr, m_cnt;
  bit       m_lock;
  bit [N-1:0] m_mask;
  int       n_grant, n_master, n_rr, n_cnt;
  bit       n_lock;
  bit [N-1:0] n_mask;
  int       burst_beats [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic check(string tag, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // next state from the bus rules: burst length table, nearest requester after rr pointer
  task automatic model_eval();
    bit [N-1:0] elig;
    int best, best_d, d;
    n_grant = m_grant; n_master = m_master; n_lock = m_lock;
    n_rr = m_rr; n_cnt = m_cnt; n_mask = m_mask;
    if (hreset) begin
      n_grant = DEF; n_master = DEF; n_lock = 1'b0; n_rr = DEF; n_cnt = 0; n_mask = '0;
      return;
    end
    if (hresp != 2'd0) n_cnt = 0;
    else if (hready && htrans == 2'd2) n_cnt = burst_beats[hburst] - 1;
    else if (hready && htrans == 2'd3 && m_cnt > 0) n_cnt = m_cnt - 1;
`ifdef AHB2_ARB_SPLIT_EN
    if (hresp == 2'd3 && !hready) n_mask[m_master] = 1'b1;
    n_mask = n_mask & ~hsplit;
    elig = hbusreq & ~m_mask;
`else
    elig = hbusreq;
`endif
    if (!hready) return;
    n_master = m_grant;
    n_lock   = hlock[m_grant];
    if (n_cnt > 1 || (hlock[m_grant] && elig[m_grant])) return;
    best = -1; best_d = N;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        d = (i - m_rr - 1 + N) % N;
        if (d < best_d) begin best_d = d; best = i; end
      end
    end
    if (best >= 0) begin
      n_grant = best; n_rr = best;
    end else begin
      n_grant = DEF;
      if (m_mask[DEF]) begin
        for (int i = N - 1; i >= 0; i--) if (!m_mask[i]) n_grant = i;
      end
    end
  endtask

  task automatic cycle();
    model_eval();
    @(posedge hclk);
    #1;
    m_grant = n_grant; m_master = n_master; m_lock = n_lock;
    m_rr = n_rr; m_cnt = n_cnt; m_mask = n_mask;
    check("hgrant", int'(hgrant), 1 << m_grant);
    check("hmaster", int'(hmaster), m_master);
    check("hmastlock", int'(hmastlock), int'(m_lock));
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
    hbusreq = req; hlock = lck; htrans = tr; hburst = bu; hready = rdy; hresp = rsp;
  endtask

  task automatic do_reset();
    drive('0, '0, 2'd0, 3'd0, 1'b1, 2'd0);
    hreset = 1'b1;
    cycle();
    hreset = 1'b0;
  endtask

  int exp_g [6] = '{2, 4, 8, 2, 4, 8};
  int exp_m [6] = '{0, 1, 2, 3, 1, 2};

  initial begin
    m_grant = DEF; m_master = DEF; m_lock = 1'b0; m_rr = DEF; m_cnt = 0; m_mask = '0;
`ifdef AHB2_ARB_SPLIT_EN
    hsplit = '0;
`endif
    do_reset();
    do_reset();

    // parked on default master with no requests
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("park_grant", int'(hgrant), 1);
      check("park_master", int'(hmaster), 0);
    end

    // round robin among M1..M3 with single transfers
    drive(4'b1110, '0, 2'd2, 3'd0, 1'b1, 2'd0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_grant", int'(hgrant), exp_g[k]);
      check("rr_master", int'(hmaster), exp_m[k]);
    end

    // INCR4 from M1 with M2 waiting; wait states inside the burst
    do_reset();
    drive(4'b0010, '0, 2'd0, 3'd0, 1'b1, 2'd0);
    cycle();
    check("incr4_own", int'(hgrant), 2);
    drive(4'b0110, '0, 2'd2, 3'd3, 1'b1, 2'd0);
    cycle();
    check("incr4_nseq", int'(hgrant), 2);
    htrans = 2'd3;
    cycle();
    check("incr4_seq1", int'(hgrant), 2);
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("incr4_wait", int'(hgrant), 2);
    end
    hready = 1'b1;
    cycle();
    check("incr4_seq2", int'(hgrant), 4);
    cycle();
    check("incr4_handover", int'(hmaster), 2);

    // locked sequence from M3 with M0 requesting
    do_reset();
    drive(4'b1001, 4'b1000, 2'd0, 3'd0, 1'b1, 2'd0);
    cycle();
    check("lock_grant0", int'(hgrant), 8);
    htrans = 2'd2;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("lock_hold", int'(hgrant), 8);
      check("lock_mastlock", int'(hmastlock), 1);
    end
    hlock = '0;
    cycle();
    check("lock_release", int'(hgrant), 1);

`ifdef AHB2_ARB_SPLIT_EN
    // M1 split: M2 wins until hsplit[1] releases M1
    do_reset();
    drive(4'b0010, '0, 2'd0, 3'd0, 1'b1, 2'd0);
    cycle();
    htrans = 2'd2;
    cycle();
    check("split_owner", int'(hmaster), 1);
    drive(4'b0110, '0, 2'd0, 3'd0, 1'b0, 2'd3);
    cycle();
    hready = 1'b1;
    cycle();
    check("split_m2", int'(hgrant), 4);
    hresp = 2'd0; hsplit = 4'b0010;
    cycle();
    hsplit = '0;
    cycle();
    check("split_release", int'(hgrant), 2);
`endif

    // randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int r;
      hreset = ($urandom_range(499) == 0);
      if ($urandom_range(9) < 3) hbusreq[$urandom_range(N-1)] = ~hbusreq[$urandom_range(N-1)];
      if ($urandom_range(9) < 1) begin
        int li;
        li = $urandom_range(N-1);
        hlock[li] = ~hlock[li];
      end
      r = $urandom_range(19);
      htrans = (r < 5) ? 2'd2 : (r < 14) ? 2'd3 : (r < 18) ? 2'd0 : 2'd1;
      hburst = 3'($urandom_range(7));
      hready = ($urandom_range(9) < 8);
      r = $urandom_range(39);
      hresp = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd0;
`ifdef AHB2_ARB_SPLIT_EN
      hsplit = '0;
      if ($urandom_range(19) == 0) hsplit[$urandom_range(N-1)] = 1'b1;
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb2_arbiter.md
Name: ahb2_arbiter

Overview:
Central AMBA2 AHB (IHI 0011A) bus arbiter for a multi-master AHB2 fabric. Collects hbusreq/hlock from NUM_MST masters and drives one-hot hgrant. Drives hmaster/hmastlock to the address/data mux and slaves. Round-robin fairness; fixed-length bursts and locked sequences are never broken; parks on a default master when idle.

Parameters:
NUM_MST, 4, number of masters (2..16)
DEFAULT_MST, 0, master granted when no request pending (parking master)
MW, $clog2(NUM_MST), hmaster width (derived, not overridable)

Ports:
hclk  input  1  bus clock
hreset  input  1  synchronous, active-high reset
hbusreq  input  NUM_MST  per-master bus request
hlock  input  NUM_MST  per-master locked-access request
htrans  input  2  shared address-phase htrans (post-mux)
hburst  input  3  shared address-phase hburst (post-mux)
hready  input  1  shared bus hready
hresp  input  2  shared bus hresp
hgrant  output  NUM_MST  one-hot grant
hmaster  output  MW  current address-bus owner index
hmastlock  output  1  current transfer is locked

Behaviour:
- Reset (hreset=1 at posedge): hgrant=one-hot(DEFAULT_MST), hmaster=DEFAULT_MST, hmastlock=0, rr_ptr=DEFAULT_MST, beat_cnt=0. Reset mid-burst drops the burst; no state survives.
- Accepted beat = posedge with hready=1. All register updates below happen only on accepted beats unless stated.
- Burst counter beat_cnt (5 bits), counts SEQ beats still to issue:
  - NONSEQ accepted: load SINGLE/INCR=0, WRAP4/INCR4=3, WRAP8/INCR8=7, WRAP16/INCR16=15.
  - SEQ accepted with beat_cnt>0: decrement.
  - IDLE/BUSY: hold.
  - Any cycle with hresp!=OKAY (hready ignored): clear to 0, burst abandoned.
  - cnt_next = value after this edge's update.
- Ownership: on accepted beat, hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)]. Values present before the edge are used. One-cycle handover per AHB2.
- Arbitration (hgrant update), on accepted beat only; hgrant holds when hready=0:
  - Hold if cnt_next>1 (early grant: switching at cnt_next==1 lets the new owner drive address right after the final beat).
  - Hold if hlock[index(hgrant)]=1 and hbusreq of that master=1.
  - Otherwise pick the first requesting master searching rr_ptr+1, rr_ptr+2, ... (mod NUM_MST) and ending with rr_ptr itself.
  - If no request is pending, grant DEFAULT_MST.
  - rr_ptr <= granted index only when a real request won (parking does not move rr_ptr).
- hgrant is registered and always exactly one-hot, never all-zero.
- Simultaneous events:
  - Request arrives on the same edge as the final beat: it is eligible at that edge.
  - Owner drops hbusreq mid fixed burst: grant is still held until cnt_next<=1.
  - Lock is released when hlock falls: re-arbitrate on the next accepted beat.
- Undefined htrans/hburst (X) after reset is treated as IDLE/SINGLE.

Optional Feature:
AHB2_ARB_SPLIT_EN:
- Adds input port hsplit [NUM_MST] and an internal split_mask [NUM_MST], reset 0.
- When hresp==SPLIT and hready=0: set split_mask[hmaster].
- hsplit[i]=1 clears split_mask[i]; a clear wins over a set in the same cycle.
- Masked masters are excluded from arbitration and from lock hold.
- If DEFAULT_MST is masked, park on the lowest unmasked index.
- Without the macro: no hsplit port, SPLIT treated like RETRY (only clears beat_cnt).

Test Plan:
- Reset, no requests -> hgrant=0001, hmaster=0, hmastlock=0; stays parked for 10 cycles.
- M1,M2,M3 hbusreq held, SINGLE transfers, hready=1 -> grant order 1,2,3,1,2,3 on consecutive edges; hmaster lags hgrant by one edge.
- M1 INCR4 (NONSEQ+3 SEQ) while M2 requests -> hgrant stays 0010 until the edge where the 2nd SEQ is accepted, then 0100; hmaster=2 on the edge after the 3rd SEQ.
- M2 INCR8 with hready=0 inserted for 3 cycles mid-burst -> no grant change during wait states; handover after 7 SEQ as in the INCR4 case.
- M3 hlock=1, hbusreq=1 for 6 beats with M0 requesting -> hgrant=1000, hmastlock=1 throughout; M0 granted on the first accepted beat after hlock falls.
- (AHB2_ARB_SPLIT_EN) M1 receives SPLIT, M1 and M2 request -> M2 granted; pulse hsplit[1] -> M1 granted on the next arbitration edge. INCR4 RETRY mid-burst clears beat_cnt, and re-arbitration is allowed immediately.
